// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a one-entry skid buffer, flush-to-bubble and a
// saturating back-pressure counter. in_ready is decoded from registered state only.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             out_valid_r;
    logic [1:0]       occupancy_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             in_xfer_s;
    logic             out_xfer_s;

    assign in_ready   = (state_r != FULL) & ~flush & ~rst;
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid_r & out_ready;

    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occupancy_r;
    assign stall_cnt = stall_cnt_r;

    // State, storage and counter update; main_r is kept at NOP_VALUE whenever empty
    // so out_data can be driven straight from the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_r      <= NOP_VALUE;
            skid_r      <= NOP_VALUE;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_r & ~out_ready & ~flush & (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush) begin
                state_r     <= EMPTY;
                main_r      <= NOP_VALUE;
                out_valid_r <= 1'b0;
                occupancy_r <= 2'd0;
            end else begin
                case (state_r)
                    EMPTY: begin
                        if (in_xfer_s) begin
                            main_r      <= in_data;
                            state_r     <= BUSY;
                            out_valid_r <= 1'b1;
                            occupancy_r <= 2'd1;
                        end
                    end
                    BUSY: begin
                        if (in_xfer_s && out_xfer_s) begin
                            main_r <= in_data;
                        end else if (in_xfer_s) begin
                            skid_r      <= in_data;
                            state_r     <= FULL;
                            occupancy_r <= 2'd2;
                        end else if (out_xfer_s) begin
                            main_r      <= NOP_VALUE;
                            state_r     <= EMPTY;
                            out_valid_r <= 1'b0;
                            occupancy_r <= 2'd0;
                        end
                    end
                    FULL: begin
                        if (out_xfer_s) begin
                            main_r      <= skid_r;
                            state_r     <= BUSY;
                            occupancy_r <= 2'd1;
                        end
                    end
                    default: begin
                        state_r     <= EMPTY;
                        main_r      <= NOP_VALUE;
                        out_valid_r <= 1'b0;
                        occupancy_r <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register, the successor to the plain stage register between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds valid/ready handshaking, a one-entry skid buffer so `in_ready` has no combinational path from `out_ready`, and a flush that inserts a bubble. It also has a saturating back-pressure counter for performance analysis. One instance sits between each pair of stages in the stallable pipeline.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `NOP_VALUE`, 0: value driven on `out_data` whenever `out_valid`=0 (bubble encoding).
- `CNT_W`, 16: width of `stall_cnt` (≥1).

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all held entries this cycle.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  WIDTH  head entry, or `NOP_VALUE` when not valid.
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: `main` register (head, drives `out_data`) and `skid` register; state ∈ {EMPTY, BUSY, FULL}. Occupancy: 0/1/2.
- Handshake: in-transfer = `in_valid & in_ready`; out-transfer = `out_valid & out_ready`.
- `in_ready` = (state≠FULL) & ~`flush` & ~`rst`. It is decoded from registered state only and never depends on `in_valid` or `out_ready`.
- `out_valid` = (state≠EMPTY). `out_data` = `main` when valid, else `NOP_VALUE`.
- Transitions (no flush):
  - EMPTY: in-xfer → BUSY, `main`←`in_data`; else stay.
  - BUSY, in-xfer and out-xfer → BUSY, `main`←`in_data`.
  - BUSY, in-xfer only → FULL, `skid`←`in_data`.
  - BUSY, out-xfer only → EMPTY.
  - BUSY, neither → stay.
  - FULL: `in_ready`=0. Out-xfer → BUSY, `main`←`skid`; else stay.
- Order is preserved: `skid` is always younger than `main`.
- Flush has priority over every transition:
  - Next state EMPTY and `main`←`NOP_VALUE`.
  - No in-transfer occurs, since `in_ready` is forced 0.
  - An out-transfer in the same cycle still counts as consumed downstream.
  - Flush in EMPTY is a no-op apart from `main`←`NOP_VALUE`.
- `stall_cnt`:
  - +1 on every cycle with `out_valid` & ~`out_ready` & ~`flush`.
  - Holds at 2^CNT_W−1 (saturates, no wrap).
  - Cleared only by `rst`; flush does not clear it.
- Reset (synchronous): state EMPTY, `main`,`skid`←`NOP_VALUE`, `stall_cnt`←0.
  - Resulting outputs: `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, `in_ready`=0 while `rst`=1, then 1 on the first cycle after deassertion.
  - Reset mid-operation drops both entries without any out-transfer semantics.

## Timing
- Latency: an entry accepted at edge k is visible on `out_data`/`out_valid` immediately after edge k (1 cycle).
- Throughput: 1 entry/cycle while `out_ready`=1. No bubble on BUSY→BUSY.
- Stall propagation: upstream sees back-pressure one cycle after the first `out_ready`=0 with data held. The skid absorbs the entry in flight that cycle.
- Recovery: the first `out_ready`=1 in FULL drains `main`. `in_ready` returns to 1 the next cycle.
- All outputs except `in_ready` are pure register outputs. `in_ready` is state plus `flush`/`rst` gating only.

## Test plan
- Reset: hold `rst`=1 three cycles with `in_valid`=1, `in_data`=0xAAAA_AAAA → `out_valid`=0, `out_data`=0, `in_ready`=0, `occupancy`=0, `stall_cnt`=0. Release → `in_ready`=1 the next cycle.
- Streaming: `out_ready`=1, push 0x1,0x2,0x3 on consecutive cycles → `out_data` 0x1,0x2,0x3 one cycle later each, no gaps, `occupancy` stays 1.
- Skid: in BUSY with 0x10 held, drop `out_ready` while pushing 0x11 → FULL, `in_ready`=0, `occupancy`=2. Raise `out_ready` → outputs 0x10 then 0x11, then `in_ready`=1. No loss or duplication.
- Flush in FULL (0x20,0x21 held) with `in_valid`=1, `in_data`=0x22 → next cycle EMPTY, `out_data`=`NOP_VALUE`. 0x22 is not captured. 0x20/0x21 never appear.
- Counter saturation with `CNT_W`=3: hold `out_valid`=1, `out_ready`=0 for 10 cycles → `stall_cnt` reaches 7 and holds. A flush leaves it at 7. `rst` returns it to 0.
- Random valid/ready/flush soak (10k cycles) against a scoreboard queue → in-order delivery. No `in_ready`=1 while FULL. `out_data`=`NOP_VALUE` whenever `out_valid`=0.
